// File: rtl/down_count_cascade_pkg.sv
// Shared constants for the borrow-driven cascade timer.
// FSM encoding and upstream counter geometry.
package down_count_cascade_pkg;

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_ZERO = 4'h0;
  localparam logic [CNT_W-1:0] CNT_TOP  = 4'hF;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/down_count_cascade_if.sv
// Control/status bundle between the timer and its user.
// cnt_in carries the upstream 4-bit down counter.
interface down_count_cascade_if #(
  parameter int HI_W = 4
);
  import down_count_cascade_pkg::*;

  logic [CNT_W-1:0] cnt_in;
  logic             load;
  logic [HI_W-1:0]  load_val;
  logic             start;
  logic             pause;
  logic [HI_W-1:0]  hi_out;
  logic             busy;
  logic             done;
  logic             tick;

  modport master (
    output cnt_in, load, load_val, start, pause,
    input  hi_out, busy, done, tick
  );

  modport slave (
    input  cnt_in, load, load_val, start, pause,
    output hi_out, busy, done, tick
  );

endinterface

// File: rtl/down_count_cascade_borrow_detect.sv
// Registered 0->F wrap detector on the upstream counter.
// First edge after reset only primes the history.
module down_count_cascade_borrow_detect
  import down_count_cascade_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] i_cnt,
  output logic             o_tick
);

  logic [CNT_W-1:0] r_prev_cnt;
  logic             r_prev_valid;
  logic             r_tick;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prev_cnt   <= CNT_ZERO;
      r_prev_valid <= 1'b0;
      r_tick       <= 1'b0;
    end else begin
      r_tick       <= r_prev_valid
                   && (r_prev_cnt == CNT_ZERO)
                   && (i_cnt == CNT_TOP);
      r_prev_cnt   <= i_cnt;
      r_prev_valid <= 1'b1;
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/down_count_cascade.sv
// High-order countdown stage clocked by upstream wraps.
// Pulses done after hi_out+1 unpaused ticks in RUN.
module down_count_cascade
  import down_count_cascade_pkg::*;
#(
  parameter int HI_W = 4
) (
  input logic clk,
  input logic reset,
  down_count_cascade_if.slave bus
);

  logic [1:0]      r_state;
  logic [HI_W-1:0] r_hi;
  logic            r_busy;
  logic            r_done;
  logic            w_tick;

  down_count_cascade_borrow_detect u_bd (
    .clk    (clk),
    .reset  (reset),
    .i_cnt  (bus.cnt_in),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_hi    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (bus.load) begin
            r_hi <= bus.load_val;
          end else if (bus.start) begin
            r_state <= RUN;
            r_busy  <= 1'b1;
          end
        end
        RUN: begin
          // paused ticks are dropped, never queued
          if (w_tick && !bus.pause) begin
            if (r_hi != '0) begin
              r_hi <= r_hi - HI_W'(1);
            end else begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.hi_out = r_hi;
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.tick   = w_tick;

endmodule

// File: tb/tb_down_count_cascade.sv
// Directed bench for the cascade timer.
// Upstream counter model decrements once per clk.
module tb_down_count_cascade;

  localparam int HI_W = 4;

  logic clk;
  logic reset;
  bit   run_cnt;
  int   n_vec;
  int   n_err;

  down_count_cascade_if #(.HI_W(HI_W)) bus ();

  down_count_cascade #(.HI_W(HI_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    if (run_cnt) bus.cnt_in = bus.cnt_in - 4'd1;
  endtask

  task automatic wait_tick(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (bus.tick === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk(tag, {31'd0, seen}, 32'd1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_hi"}, {28'd0, bus.hi_out}, 32'd0);
    chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, bus.done}, 32'd0);
    chk({tag, "_tick"}, {31'd0, bus.tick}, 32'd0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    run_cnt = 1'b0;
    reset = 1'b1;
    bus.cnt_in = 4'h7;
    bus.load = 1'b0;
    bus.load_val = '0;
    bus.start = 1'b0;
    bus.pause = 1'b0;

    // asynchronous reset mid-cycle
    #13;
    reset = 1'b0;
    #1;
    check_zero("rst");

    // spurious-edge guard
    bus.cnt_in = 4'hF;
    cyc();
    reset = 1'b1;
    cyc();
    chk("first_edge_tick", {31'd0, bus.tick}, 32'd0);
    cyc();
    chk("f_to_f_tick", {31'd0, bus.tick}, 32'd0);
    bus.cnt_in = 4'h7;
    cyc();
    bus.cnt_in = 4'hF;
    cyc();
    chk("jump7f_tick", {31'd0, bus.tick}, 32'd0);
    bus.cnt_in = 4'h0;
    cyc();
    bus.cnt_in = 4'hF;
    cyc();
    chk("wrap_tick", {31'd0, bus.tick}, 32'd1);
    cyc();
    chk("tick_1clk", {31'd0, bus.tick}, 32'd0);
    chk("idle_busy", {31'd0, bus.busy}, 32'd0);
    run_cnt = 1'b1;

    // basic run from 3
    bus.load_val = 4'd3;
    bus.load = 1'b1;
    cyc();
    bus.load = 1'b0;
    chk("load3_hi", {28'd0, bus.hi_out}, 32'd3);
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    chk("start_busy", {31'd0, bus.busy}, 32'd1);
    for (int k = 2; k >= 0; k--) begin
      wait_tick("basic_tick");
      cyc();
      chk("basic_hi", {28'd0, bus.hi_out}, k);
      chk("basic_done0", {31'd0, bus.done}, 32'd0);
    end
    wait_tick("basic_tick4");
    cyc();
    chk("basic_done", {31'd0, bus.done}, 32'd1);
    chk("basic_busy_fall", {31'd0, bus.busy}, 32'd0);
    chk("basic_no_wrap", {28'd0, bus.hi_out}, 32'd0);
    cyc();
    chk("done_1clk", {31'd0, bus.done}, 32'd0);
    chk("idle_after", {31'd0, bus.busy}, 32'd0);

    // pause drops a tick
    bus.load_val = 4'd2;
    bus.load = 1'b1;
    cyc();
    bus.load = 1'b0;
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    bus.pause = 1'b1;
    wait_tick("pause_tick_seen");
    cyc();
    bus.pause = 1'b0;
    chk("pause_hold", {28'd0, bus.hi_out}, 32'd2);
    chk("pause_busy", {31'd0, bus.busy}, 32'd1);
    for (int k = 1; k >= 0; k--) begin
      wait_tick("pause_tick");
      cyc();
      chk("pause_hi", {28'd0, bus.hi_out}, k);
      chk("pause_done0", {31'd0, bus.done}, 32'd0);
    end
    wait_tick("pause_tick3");
    cyc();
    chk("pause_done", {31'd0, bus.done}, 32'd1);
    cyc();

    // load beats start; load ignored in RUN
    bus.load_val = 4'd5;
    bus.load = 1'b1;
    bus.start = 1'b1;
    cyc();
    bus.load = 1'b0;
    bus.start = 1'b0;
    chk("prio_hi", {28'd0, bus.hi_out}, 32'd5);
    chk("prio_idle", {31'd0, bus.busy}, 32'd0);
    cyc();
    chk("prio_still_idle", {31'd0, bus.busy}, 32'd0);
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    chk("run5_busy", {31'd0, bus.busy}, 32'd1);
    bus.load_val = 4'd9;
    bus.load = 1'b1;
    cyc();
    bus.load = 1'b0;
    chk("run_load_ign", {28'd0, bus.hi_out}, 32'd5);
    for (int k = 4; k >= 2; k--) begin
      wait_tick("run5_tick");
      cyc();
      chk("run5_hi", {28'd0, bus.hi_out}, k);
    end

    // reset mid-RUN with hi_out=2
    chk("pre_rst_busy", {31'd0, bus.busy}, 32'd1);
    #3;
    reset = 1'b0;
    #1;
    check_zero("midrst");
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("midrst_nodone", {31'd0, bus.done}, 32'd0);
    end
    reset = 1'b1;
    bus.load_val = 4'd1;
    bus.load = 1'b1;
    cyc();
    bus.load = 1'b0;
    chk("post_load1", {28'd0, bus.hi_out}, 32'd1);
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    wait_tick("post_tick1");
    cyc();
    chk("post_hi0", {28'd0, bus.hi_out}, 32'd0);
    chk("post_done0", {31'd0, bus.done}, 32'd0);
    wait_tick("post_tick2");
    cyc();
    chk("post_done", {31'd0, bus.done}, 32'd1);
    chk("post_busy", {31'd0, bus.busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/down_count_cascade.md
Name: down_count_cascade

Overview:
- Downstream consumer of the 4-bit synchronous down counter (clk, reset, out[3:0]).
- Watches the counter's output for its 0000->1111 wrap (borrow) and treats each wrap as one tick.
- Each tick decrements a loadable high-order down counter, run under start/pause control.
- When the high-order count is exhausted, pulses done: the combined low+high chain forms a programmable countdown timer.

Parameters:
- HI_W, 4, width of high-order counter and load value.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- cnt_in  input  4  output of the upstream 4-bit down counter, sampled each clk.
- load  input  1  load hi_out from load_val (honoured only in IDLE).
- load_val  input  HI_W  value to load.
- start  input  1  begin countdown (honoured only in IDLE).
- pause  input  1  while 1 in RUN, ticks are ignored and hi_out holds.
- hi_out  output  HI_W  current high-order count.
- busy  output  1  1 while state is RUN.
- done  output  1  one-cycle pulse on completion.
- tick  output  1  registered borrow-detect pulse (observability).

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; hi_out=0; busy=0; done=0; tick=0.
  - prev_cnt=0; prev_valid=0.
- Release of reset: synchronous to clk. The first edge after release only captures prev_cnt and sets prev_valid=1, so no tick is possible on that edge.
- Borrow detect:
  - Registered every clk.
  - tick=1 on the edge where prev_valid=1, prev_cnt=4'h0 and cnt_in=4'hF; otherwise tick=0.
  - prev_cnt<=cnt_in every clk.
  - Latency: tick asserts one clk after cnt_in shows F.
  - Any other jump (e.g. upstream reset to an arbitrary value) never produces a tick.
- FSM (IDLE, RUN, DONE), transitions evaluated on the registered tick:
  - IDLE:
    - load=1 -> hi_out<=load_val.
    - start=1 and load=0 -> RUN.
    - load and start together: load wins, start is ignored that cycle.
  - RUN: busy=1.
    - load and start are ignored.
    - pause=1 -> hold everything; ticks arriving while paused are lost, not queued.
    - tick=1, pause=0, hi_out!=0 -> hi_out<=hi_out-1.
    - tick=1, pause=0, hi_out==0 -> DONE; hi_out stays 0, no wrap to all-ones.
  - DONE: done=1 for exactly one clk, busy=0, then unconditionally -> IDLE.
- Completion count: from hi_out=N, done follows the (N+1)th unpaused tick in RUN. Start with hi_out=0 completes on the first tick.
- Reset mid-RUN: immediate return to the reset values above; no done pulse is produced.
- All outputs are registered; no combinational path from inputs to outputs.
- Arithmetic is unsigned HI_W-bit.

Decomposition:
- Shared package holds:
  - the state encoding constants: IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - the constants CNT_W=4, CNT_ZERO=4'h0, CNT_TOP=4'hF.
- One natural sub-module, borrow_detect: owns prev_cnt/prev_valid and emits the registered tick. The top holds the FSM and hi_out.

Test Plan (clk period 10 ns; upstream counter model decrements every clk and wraps every 16 clk):
- Reset check: reset=0 mid-cycle -> hi_out=0, busy=0, done=0, tick=0 immediately, without waiting for a clk edge.
- Basic run: load_val=3, load pulse, then start pulse -> hi_out steps 3,2,1,0 on successive wraps; done pulses once for 1 clk, 1 clk after the 4th tick; busy falls at the same edge.
- Pause: in RUN with hi_out=2, hold pause=1 across one wrap -> hi_out stays 2 and tick still pulses; after release, 3 further ticks are needed for done.
- Priority/ignore: load=1 and start=1 together with load_val=5 -> hi_out=5, state IDLE. In RUN, load_val=9 with load=1 -> hi_out unchanged.
- Spurious-edge guard: right after reset, present cnt_in=F; force upstream jump 7->F -> no tick. Only the 0->F wrap ticks.
- Reset mid-operation: reset=0 while busy=1 and hi_out=2 -> all outputs 0 at once, no done pulse. After release, a new load_val=1 and start complete after 2 ticks.
